// File: rtl/seq_1101_pkg.sv
// Shared state encodings for the 1101 serial pattern detector.
package seq_1101_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S11   = 3'd2,
    S110  = 3'd3,
    S1101 = 3'd4
  } state_t;

endpackage

// File: rtl/seq_1101_sat_counter.sv
// Saturating up-counter: counts inc pulses and parks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_1101.sv
// Moore detector for the serial pattern 1101 with a saturating match counter.
//
// state | meaning
// S0    | no useful prefix seen
// S1    | seen 1
// S11   | seen 11 (further 1s keep us here)
// S110  | seen 110
// S1101 | pattern complete, out high this cycle
module seq_1101
  import seq_1101_pkg::*;
#(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic [2:0]       state_o
);

  // Held as plain bits so illegal encodings 5-7 are representable and recovered.
  logic [STATE_W-1:0] state_q;
  state_t             state_nxt;
  logic               hit;

  always_comb begin
    state_nxt = S0;
    case (state_q)
      S0:      state_nxt = in ? S1  : S0;
      S1:      state_nxt = in ? S11 : S0;
      S11:     state_nxt = in ? S11 : S110;
      S110:    state_nxt = in ? S1101 : S0;
      S1101: begin
        if (in) state_nxt = (OVERLAP != 0) ? S11 : S1;
        else    state_nxt = S0;
      end
      default: state_nxt = S0;
    endcase
  end

  assign hit = (state_nxt == S1101);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
      out     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      out     <= hit;
    end
  end

  assign state_o = state_q;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_1101.sv
// Bench for seq_1101: three instances (overlap, non-overlap, 2-bit saturating) on one stream.
module tb_seq_1101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_b = 1'b0;

  logic       out_ov, out_no, out_sat;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_sat;
  logic [2:0] st_ov, st_no, st_sat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_1101 #(.OVERLAP(1), .CNT_W(8)) dut_ov (
    .clk(clk), .rst(rst), .in(in_b), .out(out_ov), .match_count(cnt_ov), .state_o(st_ov));
  seq_1101 #(.OVERLAP(0), .CNT_W(8)) dut_no (
    .clk(clk), .rst(rst), .in(in_b), .out(out_no), .match_count(cnt_no), .state_o(st_no));
  seq_1101 #(.OVERLAP(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in(in_b), .out(out_sat), .match_count(cnt_sat), .state_o(st_sat));

  typedef struct {
    logic       o_ov, o_no, o_sat;
    logic [7:0] c_ov, c_no;
    logic [1:0] c_sat;
  } exp_t;

  exp_t sb[$];

  // Reference model: sliding window of the last four bits, counting fresh bits
  // since reset (and, for non-overlap mode, since the last detection).
  logic [3:0] m_sh;
  int         m_nb_ov, m_nb_no;
  logic [7:0] m_c_ov, m_c_no;
  logic [1:0] m_c_sat;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    m_sh = 4'b0; m_nb_ov = 0; m_nb_no = 0;
    m_c_ov = 8'd0; m_c_no = 8'd0; m_c_sat = 2'd0;
    sb.delete();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    in_b = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    model_clear();
    chk("rst_out_ov", {7'd0, out_ov}, 8'd0);
    chk("rst_out_no", {7'd0, out_no}, 8'd0);
    chk("rst_cnt_ov", cnt_ov, 8'd0);
    chk("rst_cnt_sat", {6'd0, cnt_sat}, 8'd0);
    chk("rst_state", {5'd0, st_ov}, 8'd0);
  endtask

  task automatic step(input logic b);
    exp_t e;
    exp_t got;
    logic det_ov, det_no;
    @(negedge clk);
    rst = 1'b0;
    in_b = b;
    m_sh = {m_sh[2:0], b};
    m_nb_ov++;
    m_nb_no++;
    det_ov = (m_nb_ov >= 4) && (m_sh == 4'b1101);
    det_no = (m_nb_no >= 4) && (m_sh == 4'b1101);
    if (det_no) m_nb_no = 0;
    if (det_ov && m_c_ov != 8'hff) m_c_ov = m_c_ov + 8'd1;
    if (det_no && m_c_no != 8'hff) m_c_no = m_c_no + 8'd1;
    if (det_ov && m_c_sat != 2'd3) m_c_sat = m_c_sat + 2'd1;
    e.o_ov = det_ov; e.o_no = det_no; e.o_sat = det_ov;
    e.c_ov = m_c_ov; e.c_no = m_c_no; e.c_sat = m_c_sat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("out_ov", {7'd0, out_ov}, {7'd0, got.o_ov});
    chk("out_no", {7'd0, out_no}, {7'd0, got.o_no});
    chk("out_sat", {7'd0, out_sat}, {7'd0, got.o_sat});
    chk("cnt_ov", cnt_ov, got.c_ov);
    chk("cnt_no", cnt_no, got.c_no);
    chk("cnt_sat", {6'd0, cnt_sat}, {6'd0, got.c_sat});
  endtask

  task automatic run_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i]);
  endtask

  initial begin
    model_clear();

    // Basic overlap vs non-overlap stream.
    do_reset(2);
    run_bits(32'b1101101, 7);
    chk("seq_ov_count", cnt_ov, 8'd2);
    chk("seq_no_count", cnt_no, 8'd1);

    // S11 self-loop.
    do_reset(1);
    run_bits(32'b11101, 5);
    chk("loop11_count", cnt_ov, 8'd1);

    // Reset mid-pattern discards progress; first edge after release is a normal S0 move.
    do_reset(1);
    run_bits(32'b110, 3);
    do_reset(1);
    step(1'b1);
    chk("midrst_state_ov", {5'd0, st_ov}, 8'd1);
    chk("midrst_state_no", {5'd0, st_no}, 8'd1);
    run_bits(32'b101, 3);
    chk("midrst_full_count", cnt_ov, 8'd1);

    // Reset while in S1101.
    do_reset(1);
    run_bits(32'b1101, 4);
    chk("s1101_state", {5'd0, st_ov}, 8'd4);
    do_reset(1);
    run_bits(32'b101, 3);
    chk("s1101_rst_count", cnt_ov, 8'd0);

    // Saturation with a 2-bit counter.
    do_reset(1);
    run_bits(32'b1101101101101101, 16);
    chk("sat_count", {6'd0, cnt_sat}, 8'd3);
    chk("sat_ov_count", cnt_ov, 8'd5);
    run_bits(32'b0001101, 7);
    chk("sat_hold", {6'd0, cnt_sat}, 8'd3);

    // Illegal encodings recover to S0 in one edge.
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      rst = 1'b0;
      in_b = 1'b1;
      force dut_ov.state_q = 3'(k);
      #1;
      release dut_ov.state_q;
      @(posedge clk);
      #1;
      chk("illegal_state", {5'd0, st_ov}, 8'd0);
      chk("illegal_out", {7'd0, out_ov}, 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
